bus_responder: RTL and testbench

//  Target side of the CPU core's memory bus: the core drives address/data/read_en,

---
 rtl/bus_responder.sv | 146 ++++++++++++++
 tb/tb_bus_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module  : bus_responder
// Brief   : Zero-wait-state bus target: byte RAM plus an I/O page with TX FIFO and RX holding register.
// Revision: 1.0
// ============================================================================
module bus_responder #(
  parameter int          RAM_AW   = 10,
  parameter logic [15:0] RAM_BASE = 16'h0000,
  parameter logic [15:0] IO_BASE  = 16'hD000,
  parameter int          FIFO_AW  = 2
) (
  input  logic        ph0,
  input  logic        resetb,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic        read_en,
  output logic [7:0]  rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int             DEPTH      = 2**FIFO_AW;
  localparam int             CW         = FIFO_AW + 1;
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [7:0]     OFF_TXDATA = 8'd0;
  localparam logic [7:0]     OFF_STATUS = 8'd1;
  localparam logic [7:0]     OFF_RXDATA = 8'd2;
  localparam logic [7:0]     OFF_RSVD   = 8'd3;

  logic [7:0]         mem_q [2**RAM_AW];
  logic [7:0]         fifo_q [DEPTH];
  logic [7:0]         fifo_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      tx_count_q, tx_count_d;
  logic               tx_ovf_q, tx_ovf_d;
  logic               rx_full_q, rx_full_d;
  logic [7:0]         rx_byte_q, rx_byte_d;

  logic       ram_hit, io_hit, wr_cycle;
  logic [7:0] io_off;
  logic       push, pop, push_ok, tx_full, tx_empty;
  logic       ovf_clr, rx_cap, rx_pop;
  logic [7:0] status;

  assign ram_hit  = address[15:RAM_AW] == RAM_BASE[15:RAM_AW];
  assign io_hit   = !ram_hit && (address[15:8] == IO_BASE[15:8]);
  assign io_off   = address[7:0];
  assign wr_cycle = !read_en;

  assign tx_full  = tx_count_q == DEPTH_C;
  assign tx_empty = tx_count_q == '0;
  assign tx_valid = !tx_empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign rx_ready = !rx_full_q;

  assign pop      = tx_valid && tx_ready;
  assign push     = wr_cycle && io_hit && (io_off == OFF_TXDATA);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok  = push && (!tx_full || pop);
  assign ovf_clr  = wr_cycle && io_hit && (io_off == OFF_STATUS) && wdata[3];
  assign rx_cap   = rx_valid && !rx_full_q;
  assign rx_pop   = read_en && io_hit && (io_off == OFF_RXDATA) && rx_full_q;

  assign status = {1'b0, 3'(tx_count_q), tx_ovf_q, rx_full_q, tx_empty, tx_full};

  always_comb begin
    rdata = 8'hFF;
    if (ram_hit) begin
      rdata = mem_q[address[RAM_AW-1:0]];
    end else if (io_hit) begin
      case (io_off)
        OFF_TXDATA: rdata = 8'h00;
        OFF_STATUS: rdata = status;
        OFF_RXDATA: rdata = rx_full_q ? rx_byte_q : 8'h00;
        OFF_RSVD:   rdata = 8'h00;
        default:    rdata = 8'hFF;
      endcase
    end
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_count_d = tx_count_q;
    tx_ovf_d   = tx_ovf_q;
    rx_full_d  = rx_full_q;
    rx_byte_d  = rx_byte_q;

    if (push_ok) begin
      fifo_d[wr_ptr_q] = wdata;
      wr_ptr_d         = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase

    // Overflow set takes precedence over a same-cycle clear.
    if (ovf_clr) tx_ovf_d = 1'b0;
    if (push && !push_ok) tx_ovf_d = 1'b1;

    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end
  end

  always_ff @(posedge ph0 or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_count_q <= '0;
      tx_ovf_q   <= 1'b0;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= 8'h00;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_count_q <= tx_count_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge ph0) begin
    if (wr_cycle && ram_hit) mem_q[address[RAM_AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_responder
// Brief   : Directed self-checking bench for bus_responder.
// Revision: 1.0
// ============================================================================
module tb_bus_responder;

  logic        ph0 = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] address = 16'hE000;
  logic [7:0]  wdata = 8'h00;
  logic        read_en = 1'b1;
  logic [7:0]  rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int vec_cnt = 0;
  int err_cnt = 0;

  bus_responder dut (
    .ph0      (ph0),
    .resetb   (resetb),
    .address  (address),
    .wdata    (wdata),
    .read_en  (read_en),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 ph0 = ~ph0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph0);
    #1;
  endtask

  task automatic idle();
    address = 16'hE000;
    read_en = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address = a;
    wdata   = d;
    read_en = 1'b0;
    tick();
    idle();
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    address = a;
    read_en = 1'b1;
    #1;
    check(tag, rdata, exp);
    tick();
    idle();
  endtask

  logic [7:0] drain1 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] drain2 [4] = '{8'h22, 8'h33, 8'h44, 8'h77};

  initial begin
    #1;
    check("rst_tx_valid", 8'(tx_valid), 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_ready", 8'(rx_ready), 8'h01);
    #11 resetb = 1'b1;
    tick();

    // RAM and decode
    bus_write(16'h0123, 8'hA5);
    read_chk("ram_rd", 16'h0123, 8'hA5);
    read_chk("unmapped", 16'hE000, 8'hFF);
    bus_write(16'h03FF, 8'h5A);
    read_chk("ram_top", 16'h03FF, 8'h5A);
    read_chk("ram_end+1", 16'h0400, 8'hFF);
    read_chk("status_rst", 16'hD001, 8'h02);
    read_chk("txdata_rd", 16'hD000, 8'h00);
    read_chk("rsvd_rd", 16'hD003, 8'h00);
    read_chk("io_off4", 16'hD004, 8'hFF);
    read_chk("io_offFF", 16'hD0FF, 8'hFF);
    bus_write(16'hD003, 8'h12);
    read_chk("rsvd_wr_ign", 16'hD003, 8'h00);

    // Fill past full with sink stalled
    check("pre_push_valid", 8'(tx_valid), 8'h00);
    bus_write(16'hD000, 8'h01);
    check("push_lat_valid", 8'(tx_valid), 8'h01);
    check("push_lat_data", tx_data, 8'h01);
    for (int i = 2; i <= 5; i++) bus_write(16'hD000, 8'(i));
    read_chk("status_full_ovf", 16'hD001, 8'h49);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", 8'(tx_valid), 8'h01);
      check("drain_data", tx_data, drain1[i]);
      tick();
    end
    check("drained_valid", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;
    read_chk("status_ovf_empty", 16'hD001, 8'h0A);
    bus_write(16'hD001, 8'h08);
    read_chk("status_ovf_clr", 16'hD001, 8'h02);

    // Push into a full FIFO while the head pops
    bus_write(16'hD000, 8'h11);
    bus_write(16'hD000, 8'h22);
    bus_write(16'hD000, 8'h33);
    bus_write(16'hD000, 8'h44);
    read_chk("status_full", 16'hD001, 8'h41);
    address  = 16'hD000;
    wdata    = 8'h77;
    read_en  = 1'b0;
    tx_ready = 1'b1;
    #1;
    check("fpp_head", tx_data, 8'h11);
    tick();
    idle();
    tx_ready = 1'b0;
    read_chk("status_fpp", 16'hD001, 8'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain2_data", tx_data, drain2[i]);
      tick();
    end
    check("drain2_valid", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;

    // RX holding register
    check("rx_ready_idle", 8'(rx_ready), 8'h01);
    rx_data  = 8'h3C;
    rx_valid = 1'b1;
    tick();
    check("rx_ready_full", 8'(rx_ready), 8'h00);
    rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    read_chk("status_rx", 16'hD001, 8'h06);
    read_chk("rxdata_pop", 16'hD002, 8'h3C);
    check("rx_ready_after_pop", 8'(rx_ready), 8'h01);
    read_chk("rxdata_empty", 16'hD002, 8'h00);

    // Asynchronous reset mid-operation
    bus_write(16'hD000, 8'hAA);
    bus_write(16'hD000, 8'hBB);
    bus_write(16'hD000, 8'hCC);
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("pre_rst_valid", 8'(tx_valid), 8'h01);
    check("pre_rst_rx_ready", 8'(rx_ready), 8'h00);
    resetb = 1'b0;
    #1;
    check("arst_tx_valid", 8'(tx_valid), 8'h00);
    check("arst_tx_data", tx_data, 8'h00);
    check("arst_rx_ready", 8'(rx_ready), 8'h01);
    #2 resetb = 1'b1;
    tick();
    read_chk("ram_kept", 16'h0123, 8'hA5);
    read_chk("status_after_rst", 16'hD001, 8'h02);
    read_chk("rxdata_after_rst", 16'hD002, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
